// File: rtl/sensor_pkg.sv
// Shared definitions for the sensor receive path and the MCU SPI transmitter:
// frame constants, flag bit positions, transmitter FSM states and debug view.
package sensor_pkg;

    localparam logic [7:0] HEADER_BYTE  = 8'hAA;
    localparam int         PACKET_BYTES = 16;
    localparam int         SNAP_BYTES   = 16;

    localparam int FLAG_INIT_BIT  = 0;
    localparam int FLAG_ERR_BIT   = 1;
    localparam int FLAG_QUAT_BIT  = 2;
    localparam int FLAG_GYRO_BIT  = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2
    } spi_state_t;

    typedef struct packed {
        spi_state_t state;
        logic       cs_n_sync;
        logic       sck_sync;
    } spi_dbg_t;

    function automatic logic [7:0] make_flags(input logic initialized,
                                              input logic error,
                                              input logic quat_valid,
                                              input logic gyro_valid);
        logic [7:0] f;
        f                = 8'h00;
        f[FLAG_INIT_BIT] = initialized;
        f[FLAG_ERR_BIT]  = error;
        f[FLAG_QUAT_BIT] = quat_valid;
        f[FLAG_GYRO_BIT] = gyro_valid;
        return f;
    endfunction

endpackage

// File: rtl/mcu_spi_tx_if.sv
// SPI pins between the MCU (master) and the FPGA transmitter (slave).
// cs_n/sck are driven by the MCU asynchronously to clk; sdo is only
// meaningful while sdo_en is high.
interface mcu_spi_tx_if;
    logic cs_n;
    logic sck;
    logic sdo;
    logic sdo_en;

    modport master (output cs_n, output sck, input sdo, input sdo_en);
    modport slave  (input cs_n, input sck, output sdo, output sdo_en);
endinterface

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer plus edge detector for one asynchronous pin.
// Edges are suppressed until every stage holds a post-reset sample.
module sync_edge_det #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_sync,
    output logic o_rise,
    output logic o_fall
);

    logic       r_meta;
    logic       r_sync;
    logic       r_prev;
    logic [2:0] r_vld;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
            r_prev <= RESET_VAL;
            r_vld  <= 3'b000;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
            r_prev <= r_sync;
            r_vld  <= {r_vld[1:0], 1'b1};
        end
    end

    // A pin already at the opposite level at reset release must not look like an edge.
    assign o_sync = r_sync;
    assign o_rise = r_vld[2] & r_sync & ~r_prev;
    assign o_fall = r_vld[2] & ~r_sync & r_prev;

endmodule

// File: rtl/mcu_spi_tx.sv
// SPI Mode-0 slave transmitter: snapshots the sensor data on chip-select and
// shifts out a fixed header/flags/quaternion/gyro frame, MSB first.
module mcu_spi_tx
    import sensor_pkg::spi_dbg_t, sensor_pkg::spi_state_t, sensor_pkg::ST_IDLE,
           sensor_pkg::ST_LOAD, sensor_pkg::ST_SHIFT, sensor_pkg::SNAP_BYTES,
           sensor_pkg::make_flags;
#(
    parameter logic [7:0] HEADER_BYTE  = sensor_pkg::HEADER_BYTE,
    parameter int         PACKET_BYTES = sensor_pkg::PACKET_BYTES
) (
    input  logic               clk,
    input  logic               rst,
    mcu_spi_tx_if.slave        spi,
    input  logic               initialized,
    input  logic               error,
    input  logic               quat1_valid,
    input  logic               gyro1_valid,
    input  logic signed [15:0] quat1_w,
    input  logic signed [15:0] quat1_x,
    input  logic signed [15:0] quat1_y,
    input  logic signed [15:0] quat1_z,
    input  logic signed [15:0] gyro1_x,
    input  logic signed [15:0] gyro1_y,
    input  logic signed [15:0] gyro1_z,
    output logic               frame_done,
    output logic               frame_abort,
    output spi_dbg_t           o_dbg
);

    localparam int              CNT_W    = $clog2(PACKET_BYTES + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(PACKET_BYTES);
    localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

    spi_state_t       r_state;
    spi_state_t       w_state_next;
    logic [127:0]     r_snap;
    logic [7:0]       r_shift;
    logic             r_sdo;
    logic [2:0]       r_bit_cnt;
    logic [CNT_W-1:0] r_byte_cnt;
    logic             r_frame_done;
    logic             r_frame_abort;

    logic             w_cs_sync, w_cs_rise, w_cs_fall;
    logic             w_sck_sync, w_sck_rise, w_sck_fall;
    logic             w_full;
    logic             w_done;
    logic             w_abort;
    logic [127:0]     w_snap_in;
    logic [CNT_W-1:0] w_next_idx;
    logic [7:0]       w_next_byte;

    sync_edge_det #(.RESET_VAL(1'b1)) u_cs_sync (
        .clk     (clk),
        .rst     (rst),
        .i_async (spi.cs_n),
        .o_sync  (w_cs_sync),
        .o_rise  (w_cs_rise),
        .o_fall  (w_cs_fall)
    );

    sync_edge_det #(.RESET_VAL(1'b0)) u_sck_sync (
        .clk     (clk),
        .rst     (rst),
        .i_async (spi.sck),
        .o_sync  (w_sck_sync),
        .o_rise  (w_sck_rise),
        .o_fall  (w_sck_fall)
    );

    function automatic logic [7:0] snap_byte(input logic [127:0] snap,
                                             input logic [CNT_W-1:0] idx);
        logic [7:0] b;
        b = 8'h00;
        for (int i = 0; i < SNAP_BYTES; i++) begin
            if (int'(idx) == i) b = snap[127-8*i -: 8];
        end
        return b;
    endfunction

    assign w_snap_in = {HEADER_BYTE,
                        make_flags(initialized, error, quat1_valid, gyro1_valid),
                        quat1_w, quat1_x, quat1_y, quat1_z,
                        gyro1_x, gyro1_y, gyro1_z};

    // Counted rising edges saturate at one full frame, so an over-read still completes.
    assign w_full      = (r_byte_cnt == FULL_CNT);
    assign w_next_idx  = r_byte_cnt + ONE_CNT;
    assign w_next_byte = (w_next_idx == FULL_CNT) ? 8'h00 : snap_byte(r_snap, w_next_idx);

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_done       = 1'b0;
        w_abort      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_cs_fall) w_state_next = ST_LOAD;
            end
            ST_LOAD: begin
                if (w_cs_rise) begin
                    w_abort      = 1'b1;
                    w_state_next = ST_IDLE;
                end else begin
                    w_state_next = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (w_cs_rise) begin
                    w_done       = w_full;
                    w_abort      = ~w_full;
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_snap        <= '0;
            r_shift       <= '0;
            r_sdo         <= 1'b0;
            r_bit_cnt     <= '0;
            r_byte_cnt    <= '0;
            r_frame_done  <= 1'b0;
            r_frame_abort <= 1'b0;
        end else begin
            r_frame_done  <= w_done;
            r_frame_abort <= w_abort;
            case (r_state)
                ST_LOAD: begin
                    r_bit_cnt  <= '0;
                    r_byte_cnt <= '0;
                    if (w_cs_rise) begin
                        r_sdo <= 1'b0;
                    end else begin
                        r_snap  <= w_snap_in;
                        r_sdo   <= w_snap_in[127];
                        r_shift <= {w_snap_in[126:120], 1'b0};
                    end
                end
                ST_SHIFT: begin
                    if (w_cs_rise) begin
                        r_bit_cnt  <= '0;
                        r_byte_cnt <= '0;
                        r_sdo      <= 1'b0;
                    end else begin
                        // r_shift holds the bits still to be presented, next one at the MSB.
                        if (w_sck_rise && !w_full) begin
                            if (r_bit_cnt == 3'd7) begin
                                r_bit_cnt  <= '0;
                                r_byte_cnt <= w_next_idx;
                                r_shift    <= w_next_byte;
                            end else begin
                                r_bit_cnt <= r_bit_cnt + 3'd1;
                            end
                        end
                        if (w_sck_fall) begin
                            r_sdo   <= r_shift[7];
                            r_shift <= {r_shift[6:0], 1'b0};
                        end
                    end
                end
                default: begin
                    r_bit_cnt  <= '0;
                    r_byte_cnt <= '0;
                    r_sdo      <= 1'b0;
                end
            endcase
        end
    end

    assign spi.sdo     = r_sdo;
    assign spi.sdo_en  = ~w_cs_sync;
    assign frame_done  = r_frame_done;
    assign frame_abort = r_frame_abort;
    assign o_dbg       = '{state: r_state, cs_n_sync: w_cs_sync, sck_sync: w_sck_sync};

endmodule

// File: tb/tb_mcu_spi_tx.sv
// Bench for mcu_spi_tx: acts as a Mode-0 MCU at clk/8 and checks the frame
// bytes, completion pulses and idle outputs against hand-computed values.
module tb_mcu_spi_tx;
    import sensor_pkg::*;

    logic               clk;
    logic               rst;
    logic               initialized, error, quat1_valid, gyro1_valid;
    logic signed [15:0] quat1_w, quat1_x, quat1_y, quat1_z;
    logic signed [15:0] gyro1_x, gyro1_y, gyro1_z;
    logic               frame_done, frame_abort;
    spi_dbg_t           dbg;

    mcu_spi_tx_if spi_if ();

    mcu_spi_tx dut (
        .clk         (clk),
        .rst         (rst),
        .spi         (spi_if.slave),
        .initialized (initialized),
        .error       (error),
        .quat1_valid (quat1_valid),
        .gyro1_valid (gyro1_valid),
        .quat1_w     (quat1_w),
        .quat1_x     (quat1_x),
        .quat1_y     (quat1_y),
        .quat1_z     (quat1_z),
        .gyro1_x     (gyro1_x),
        .gyro1_y     (gyro1_y),
        .gyro1_z     (gyro1_z),
        .frame_done  (frame_done),
        .frame_abort (frame_abort),
        .o_dbg       (dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int done_pulses  = 0;
    int abort_pulses = 0;
    logic [159:0] rx_bits;

    always @(negedge clk) begin
        if (frame_done)  done_pulses++;
        if (frame_abort) abort_pulses++;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, required finish before 2ms");
        $fatal(1);
    end

    // {gyro_valid, quat_valid, error, initialized}, the seven data words, bits to clock,
    // the expected 16-byte frame and whether frame_done (vs frame_abort) is expected.
    typedef struct {
        logic [3:0]   flags;
        logic [111:0] data;
        int           nbits;
        logic [127:0] exp_frame;
        logic         exp_done;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic apply_inputs(input logic [3:0] flags, input logic [111:0] data);
        {gyro1_valid, quat1_valid, error, initialized} = flags;
        {quat1_w, quat1_x, quat1_y, quat1_z, gyro1_x, gyro1_y, gyro1_z} = data;
    endtask

    task automatic cs_low();
        @(posedge clk);
        #1 spi_if.cs_n = 1'b0;
        rx_bits = '0;
        repeat (6) @(posedge clk);
    endtask

    task automatic clock_bits(input int n);
        for (int i = 0; i < n; i++) begin
            repeat (4) @(posedge clk);
            #1;
            rx_bits = {rx_bits[158:0], spi_if.sdo};
            spi_if.sck = 1'b1;
            repeat (4) @(posedge clk);
            #1 spi_if.sck = 1'b0;
        end
    endtask

    task automatic cs_high();
        repeat (4) @(posedge clk);
        #1 spi_if.cs_n = 1'b1;
        repeat (8) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_bytes(input string tag, input int nbytes, input logic [127:0] exp);
        logic [7:0] a;
        logic [7:0] e;
        for (int k = 0; k < nbytes; k++) begin
            a = rx_bits[8*(nbytes-1-k) +: 8];
            if (k < 16) e = exp[127-8*k -: 8];
            else        e = 8'h00;
            check($sformatf("%s byte%0d", tag, k), 32'(a), 32'(e));
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, " sdo"},    32'(spi_if.sdo),    32'(0));
        check({tag, " sdo_en"}, 32'(spi_if.sdo_en), 32'(0));
        check({tag, " state"},  32'(dbg.state),     32'(ST_IDLE));
    endtask

    initial begin
        int d0;
        int a0;
        logic [127:0] exp_v0;

        exp_v0 = 128'hAA0D_4000_1234_0000_0000_0000_0000_FFFE;
        vecs[0] = '{4'b1101, 112'h4000_1234_0000_0000_0000_0000_FFFE, 128, exp_v0, 1'b1};
        vecs[1] = '{4'b0010, 112'h0, 128,
                    128'hAA02_0000_0000_0000_0000_0000_0000_0000, 1'b1};
        vecs[2] = '{4'b1011, 112'h8001_7FFF_00FF_FF00_A5A5_5A5A_0001, 128,
                    128'hAA0B_8001_7FFF_00FF_FF00_A5A5_5A5A_0001, 1'b1};
        vecs[3] = '{4'b0001, 112'h1111_2222_3333_4444_5555_6666_7777, 160,
                    128'hAA01_1111_2222_3333_4444_5555_6666_7777, 1'b1};
        vecs[4] = '{4'b0100, 112'h0102_0304_0506_0708_090A_0B0C_0D0E, 40,
                    128'hAA04_0102_0304_0506_0708_090A_0B0C_0D0E, 1'b0};

        rst = 1'b1;
        spi_if.cs_n = 1'b1;
        spi_if.sck  = 1'b0;
        apply_inputs(4'b0000, 112'h0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        check_idle("reset");
        check("reset done",  32'(frame_done),  32'(0));
        check("reset abort", 32'(frame_abort), 32'(0));
        #1 rst = 1'b0;
        repeat (6) @(posedge clk);

        // table-driven frames: full, flags-only, mixed pattern, over-read, short read
        for (int v = 0; v < 5; v++) begin
            apply_inputs(vecs[v].flags, vecs[v].data);
            d0 = done_pulses;
            a0 = abort_pulses;
            cs_low();
            clock_bits(vecs[v].nbits);
            cs_high();
            check_bytes($sformatf("vec%0d", v), vecs[v].nbits / 8, vecs[v].exp_frame);
            check($sformatf("vec%0d done pulses", v),  32'(done_pulses - d0),  32'(vecs[v].exp_done ? 1 : 0));
            check($sformatf("vec%0d abort pulses", v), 32'(abort_pulses - a0), 32'(vecs[v].exp_done ? 0 : 1));
            check_idle($sformatf("vec%0d end", v));
            repeat (4) @(posedge clk);
        end

        // input change after byte 3 must not reach the frame in flight
        apply_inputs(vecs[0].flags, vecs[0].data);
        d0 = done_pulses;
        cs_low();
        clock_bits(32);
        quat1_x = 16'hBEEF;
        clock_bits(96);
        cs_high();
        check_bytes("midchg", 16, exp_v0);
        check("midchg done pulses", 32'(done_pulses - d0), 32'(1));
        cs_low();
        clock_bits(128);
        cs_high();
        check_bytes("midchg next", 16, 128'hAA0D_4000_BEEF_0000_0000_0000_0000_FFFE);

        // data update coinciding with the cs_n falling edge lands in the snapshot
        @(posedge clk);
        #1 spi_if.cs_n = 1'b0;
        quat1_x = 16'hCAFE;
        rx_bits = '0;
        repeat (6) @(posedge clk);
        clock_bits(128);
        cs_high();
        check_bytes("coincide", 16, 128'hAA0D_4000_CAFE_0000_0000_0000_0000_FFFE);

        // reset in the middle of byte 5, cs_n held low across reset release
        apply_inputs(vecs[0].flags, vecs[0].data);
        d0 = done_pulses;
        a0 = abort_pulses;
        cs_low();
        clock_bits(44);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_idle("rst mid");
        check("rst mid done",  32'(frame_done),  32'(0));
        check("rst mid abort", 32'(frame_abort), 32'(0));
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (10) @(posedge clk);
        clock_bits(8);
        repeat (6) @(posedge clk);
        @(negedge clk);
        check("rst hold-low state", 32'(dbg.state), 32'(ST_IDLE));
        check("rst hold-low sdo",   32'(spi_if.sdo), 32'(0));
        cs_high();
        check("rst no done",  32'(done_pulses - d0),  32'(0));
        check("rst no abort", 32'(abort_pulses - a0), 32'(0));
        cs_low();
        clock_bits(128);
        cs_high();
        check_bytes("post rst", 16, exp_v0);
        check("post rst done pulses", 32'(done_pulses - d0), 32'(1));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mcu_spi_tx.md
MCU_SPI_TX -- requirements
Module: mcu_spi_tx

Interface
REQ-001 Parameter HEADER_BYTE, 8'hAA, first byte of every frame sent to the MCU.
REQ-002 Parameter PACKET_BYTES, 16, number of bytes in one frame.
REQ-003 clk  in  1  FPGA system clock; the only clock in the block.
REQ-004 rst  in  1  reset, synchronous to clk, active-high.
REQ-005 cs_n  in  1  MCU chip select, active low, asynchronous to clk.
REQ-006 sck  in  1  MCU SPI clock, SPI Mode 0, asynchronous to clk.
REQ-007 sdo  out  1  MISO data to the MCU.
REQ-008 sdo_en  out  1  MISO output enable; high while the synchronized cs_n is low.
REQ-009 initialized, error, quat1_valid, gyro1_valid  in  1 each  status from the upstream sensor receiver.
REQ-010 quat1_w, quat1_x, quat1_y, quat1_z, gyro1_x, gyro1_y, gyro1_z  in  16 signed each  sensor data from the upstream receiver.
REQ-011 frame_done  out  1  one-clk pulse when the frame completes.
REQ-012 frame_abort  out  1  one-clk pulse when the frame is aborted.

Function
REQ-013 cs_n and sck SHALL each pass through a 2-flop synchronizer; all edge detection SHALL use the synchronized copies.
REQ-014 Frame layout, MSB-first bytes, 16-bit fields MSB byte first:
- byte 0: HEADER_BYTE
- byte 1: flags {4'b0, gyro1_valid, quat1_valid, error, initialized}
- bytes 2-9: quat w, x, y, z
- bytes 10-15: gyro x, y, z
REQ-015 FSM states SHALL be IDLE, LOAD and SHIFT.
- IDLE: on a synced cs_n falling edge, go to LOAD.
- LOAD (1 cycle): capture all data and status inputs into a 128-bit snapshot, load byte 0 into the shift register, drive its MSB on sdo, go to SHIFT.
REQ-016 In SHIFT:
- On a synced sck rising edge, increment bit_cnt (0-7).
- On a synced sck falling edge, shift the next bit onto sdo.
- After the 8th rising edge, load the next snapshot byte and increment byte_cnt.
REQ-017 The snapshot SHALL NOT change while in LOAD or SHIFT; input changes during a frame appear only in the next frame.
REQ-018 If an input update and the cs_n falling edge coincide, the snapshot SHALL take the input value present in the LOAD cycle.
REQ-019 After PACKET_BYTES bytes have been sent, further sck edges SHALL shift out 8'h00 and byte_cnt SHALL saturate.
REQ-020 On a synced cs_n rising edge in SHIFT:
- If exactly PACKET_BYTES*8 rising edges were counted, pulse frame_done; otherwise pulse frame_abort.
- In both cases, clear the counters, force sdo to 0 and return to IDLE.
REQ-021 The worst-case latency from the cs_n falling pin edge to a valid first bit on sdo SHALL be 4 clk cycles.
REQ-022 The MCU SHALL provide at least 4 clk cycles of CS setup before the first sck edge, and SHALL run sck at no more than clk/8.
REQ-023 An sck edge seen while in IDLE SHALL be ignored.

Reset
REQ-024 While rst is high, all of the following SHALL be held on every clk edge:
- FSM in IDLE
- sdo=0, sdo_en=0, frame_done=0, frame_abort=0
- counters=0, snapshot=0
- synchronizers set to cs_n=1, sck=0
REQ-025 Reset asserted mid-frame SHALL abandon the frame without pulsing frame_abort.
REQ-026 After reset, the block SHALL wait for a fresh cs_n falling edge; a cs_n already held low at reset release SHALL NOT start a frame.

Structure
REQ-027 HEADER_BYTE, PACKET_BYTES, the flags bit positions and the FSM state enum SHALL live in a shared package, sensor_pkg, which is also used by the upstream receiver.
REQ-028 The synchronizer plus edge detector SHALL be one reusable sub-module, sync_edge_det, instantiated once for cs_n and once for sck.

Verification
REQ-029 A bench SHALL cover these directed scenarios:
- Full frame: initialized=1, quat1_valid=1, gyro1_valid=1, quat1_w=16384, quat1_x=16'h1234, gyro1_z=-2 (16'hFFFE); 128-bit Mode-0 read at clk/8 -> bytes AA 0D 40 00 12 34 ... FF FE, one frame_done pulse.
- Data change mid-frame: quat1_x changes after byte 3 -> current frame still shows 12 34; next frame shows the new value.
- Short read: cs_n rises after 40 sck edges -> frame_abort pulses once, frame_done stays 0, sdo=0, FSM in IDLE.
- Over-read: 20 bytes clocked -> bytes 16-19 read as 00, frame_done pulses.
- Reset mid-frame: rst asserted at byte 5 -> all outputs 0 the next cycle, no pulse; cs_n held low through reset release -> no frame until cs_n goes high and then low again.
- error=1, initialized=0 -> flags byte reads 02.
